// File: rtl/wb_arbiter.sv
// Writeback scheduler: one-entry holding slot per functional unit,
// round-robin grant into a registered regfile write-port stage.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NSRC = 3,
    parameter int RW   = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [NSRC-1:0]      req_valid,
    output logic [NSRC-1:0]      req_ready,
    input  logic [NSRC*RW-1:0]   req_rd,
    input  logic [NSRC*XLEN-1:0] req_data,
    input  logic [NSRC-1:0]      req_fp,
    output logic                 wb_en,
    output logic                 wb_fen,
    output logic [RW-1:0]        wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [1:0]           wb_src,
    output logic                 busy
);

    localparam int PW = 2;

    logic [NSRC-1:0] slot_valid;
    logic [NSRC-1:0] slot_fp;
    logic [RW-1:0]   slot_rd   [NSRC];
    logic [XLEN-1:0] slot_data [NSRC];

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic            gany;
    logic [NSRC-1:0] grant;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NSRC);
    endfunction

    // Scan from rr_ptr; the first valid slot in wrap order wins.
    always_comb begin
        gany = 1'b0;
        gidx = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!gany && !flush && slot_valid[wrap(int'(rr_ptr) + i)]) begin
                gany = 1'b1;
                gidx = wrap(int'(rr_ptr) + i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NSRC; i++) begin
            grant[i] = gany && (int'(gidx) == i);
        end
    end

    assign req_ready = {NSRC{!flush}} & (~slot_valid | grant);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_valid <= '0;
            slot_fp    <= '0;
            for (int i = 0; i < NSRC; i++) begin
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (flush) begin
                    slot_valid[i] <= 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_fp[i]    <= req_fp[i];
                    slot_rd[i]    <= req_rd[i*RW +: RW];
                    slot_data[i]  <= req_data[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // An integer write to x0 still consumes its grant but never strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr  <= '0;
            wb_en   <= 1'b0;
            wb_fen  <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_src  <= '0;
        end else begin
            wb_en  <= gany && !slot_fp[gidx] && (slot_rd[gidx] != '0);
            wb_fen <= gany && slot_fp[gidx];
            if (gany) begin
                rr_ptr  <= wrap(int'(gidx) + 1);
                wb_rd   <= slot_rd[gidx];
                wb_data <= slot_data[gidx];
                wb_src  <= gidx;
            end
        end
    end

    assign busy = (|slot_valid) | wb_en | wb_fen;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a slot/pointer
// model derived from the writeback rules.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [14:0] req_rd = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_fp = '0;
    logic        wb_en, wb_fen, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_src;

    int total = 0;
    int bad = 0;

    bit          m_valid [3];
    logic [4:0]  m_rd    [3];
    logic [31:0] m_data  [3];
    bit          m_fp    [3];
    int          m_ptr;
    bit          e_en, e_fen;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          e_src;
    bit          acc [3];

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .NSRC(3), .RW(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data), .req_fp(req_fp),
        .wb_en(wb_en), .wb_fen(wb_fen), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_src(wb_src), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] rd,
                           input logic [31:0] d, input bit fp);
        req_valid[i]      = v;
        req_rd[i*5 +: 5]  = rd;
        req_data[i*32 +: 32] = d;
        req_fp[i]         = fp;
    endtask

    function automatic int mgrant();
        if (flush) return -1;
        for (int k = 0; k < 3; k++) begin
            if (m_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0;
            m_fp[i] = 0;
            m_rd[i] = '0;
            m_data[i] = '0;
            acc[i] = 1;
        end
        m_ptr = 0;
        e_en = 0;
        e_fen = 0;
        e_rd = '0;
        e_data = '0;
        e_src = 0;
    endtask

    task automatic check_out();
        bit eb;
        eb = m_valid[0] | m_valid[1] | m_valid[2] | e_en | e_fen;
        chk("wb_en", 64'(wb_en), 64'(e_en));
        chk("wb_fen", 64'(wb_fen), 64'(e_fen));
        chk("wb_rd", 64'(wb_rd), 64'(e_rd));
        chk("wb_data", 64'(wb_data), 64'(e_data));
        chk("wb_src", 64'(wb_src), 64'(e_src));
        chk("busy", 64'(busy), 64'(eb));
    endtask

    // Entered one time unit after a rising edge; returns likewise.
    task automatic cyc();
        int g;
        bit rdy [3];
        #1;
        g = mgrant();
        for (int i = 0; i < 3; i++) begin
            rdy[i] = !flush && (!m_valid[i] || g == i);
            chk($sformatf("ready%0d", i), 64'(req_ready[i]), 64'(rdy[i]));
        end
        @(posedge clk);
        e_en = 0;
        e_fen = 0;
        if (g >= 0) begin
            e_fen  = m_fp[g];
            e_en   = !m_fp[g] && (m_rd[g] != 0);
            e_rd   = m_rd[g];
            e_data = m_data[g];
            e_src  = g;
            m_ptr  = (g + 1) % 3;
        end
        for (int i = 0; i < 3; i++) begin
            acc[i] = req_valid[i] && rdy[i];
            if (flush) m_valid[i] = 0;
            else if (acc[i]) begin
                m_valid[i] = 1;
                m_rd[i]    = req_rd[i*5 +: 5];
                m_data[i]  = req_data[i*32 +: 32];
                m_fp[i]    = req_fp[i];
            end else if (g == i) m_valid[i] = 0;
        end
        #1;
        check_out();
    endtask

    task automatic do_reset();
        req_valid = '0;
        flush = 1'b0;
        resetn = 1'b0;
        model_reset();
        #1;
        check_out();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Held requests keep their fields until accepted.
    task automatic drive(input bit [2:0] mask, input int pct, input bit x0ok);
        logic [4:0] rd;
        for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && !acc[i]) continue;
            if (mask[i] && $urandom_range(1, 100) <= pct) begin
                rd = 5'($urandom);
                if (!x0ok && rd == 0) rd = 5'd1;
                if (x0ok && $urandom_range(0, 4) == 0) rd = 5'd0;
                set_req(i, 1, rd, $urandom, 1'($urandom));
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    initial begin
        int last [3];
        int s;

        #2;
        do_reset();

        // single request
        set_req(0, 1, 5'd5, 32'hDEADBEEF, 0);
        cyc();
        chk("t1_acc", 64'(acc[0]), 64'(1));
        chk("t1_early", 64'(wb_en), 64'(0));
        req_valid = '0;
        cyc();
        chk("t1_en", 64'(wb_en), 64'(1));
        chk("t1_rd", 64'(wb_rd), 64'(5));
        chk("t1_data", 64'(wb_data), 64'h0DEADBEEF);
        chk("t1_src", 64'(wb_src), 64'(0));
        cyc();
        chk("t1_off", 64'(wb_en), 64'(0));
        chk("t1_idle", 64'(busy), 64'(0));

        // three-way contention
        do_reset();
        set_req(0, 1, 5'd1, 32'h11, 0);
        set_req(1, 1, 5'd2, 32'h22, 1);
        set_req(2, 1, 5'd3, 32'h33, 0);
        cyc();
        req_valid = '0;
        set_req(2, 1, 5'd7, 32'h77, 0);
        cyc();
        chk("t2_en0", 64'(wb_en), 64'(1));
        chk("t2_src0", 64'(wb_src), 64'(0));
        chk("t2_blk0", 64'(acc[2]), 64'(0));
        cyc();
        chk("t2_fen1", 64'(wb_fen), 64'(1));
        chk("t2_rd1", 64'(wb_rd), 64'(2));
        chk("t2_blk1", 64'(acc[2]), 64'(0));
        cyc();
        chk("t2_en2", 64'(wb_en), 64'(1));
        chk("t2_rd2", 64'(wb_rd), 64'(3));
        chk("t2_refill", 64'(acc[2]), 64'(1));
        req_valid = '0;
        cyc();
        chk("t2_rd7", 64'(wb_rd), 64'(7));

        // x0 suppression and pointer advance
        do_reset();
        set_req(1, 1, 5'd0, 32'h1234, 0);
        cyc();
        req_valid = '0;
        cyc();
        chk("t4_en", 64'(wb_en), 64'(0));
        chk("t4_fen", 64'(wb_fen), 64'(0));
        chk("t4_src", 64'(wb_src), 64'(1));
        set_req(0, 1, 5'd9, 32'h9, 0);
        set_req(2, 1, 5'd10, 32'hA, 0);
        cyc();
        req_valid = '0;
        cyc();
        chk("t4_ptr2", 64'(wb_src), 64'(2));
        cyc();
        chk("t4_ptr0", 64'(wb_src), 64'(0));
        set_req(1, 1, 5'd0, 32'h1234, 1);
        cyc();
        req_valid = '0;
        cyc();
        chk("t4_fen_x0", 64'(wb_fen), 64'(1));
        chk("t4_rd_x0", 64'(wb_rd), 64'(0));

        // flush
        do_reset();
        set_req(0, 1, 5'd4, 32'h4, 0);
        cyc();
        req_valid = '0;
        cyc();
        set_req(0, 1, 5'd1, 32'h1, 0);
        set_req(1, 1, 5'd2, 32'h2, 0);
        set_req(2, 1, 5'd3, 32'h3, 1);
        cyc();
        req_valid = '0;
        flush = 1'b1;
        cyc();
        chk("t5_en", 64'(wb_en | wb_fen), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        flush = 1'b0;
        set_req(0, 1, 5'd11, 32'hB, 0);
        set_req(1, 1, 5'd12, 32'hC, 0);
        cyc();
        req_valid = '0;
        cyc();
        chk("t5_first", 64'(wb_rd), 64'(12));
        cyc();
        chk("t5_second", 64'(wb_rd), 64'(11));

        // round-robin fairness, then lone back-to-back refill
        do_reset();
        last = '{-1, -1, -1};
        for (int c = 0; c < 10; c++) begin
            drive(3'b101, 100, 0);
            cyc();
            if (wb_en || wb_fen) begin
                s = int'(wb_src);
                if (last[s] >= 0) chk("t3_gap", 64'((c - last[s]) <= 2), 64'(1));
                last[s] = c;
            end
        end
        for (int c = 0; c < 8; c++) begin
            drive(3'b001, 100, 0);
            cyc();
            if (c >= 3) begin
                chk("t3_b2b", 64'(wb_en | wb_fen), 64'(1));
                chk("t3_b2b_src", 64'(wb_src), 64'(0));
            end
        end

        // random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(1, 100) <= 4);
            drive(3'b111, 55, 1);
            cyc();
        end
        flush = 1'b0;

        // async reset mid-operation
        do_reset();
        set_req(0, 1, 5'd4, 32'h44, 0);
        set_req(1, 1, 5'd5, 32'h55, 0);
        set_req(2, 1, 5'd6, 32'h66, 0);
        cyc();
        cyc();
        chk("t6_pre", 64'(wb_en), 64'(1));
        #2;
        resetn = 1'b0;
        req_valid = '0;
        #1;
        chk("t6_en", 64'(wb_en), 64'(0));
        chk("t6_fen", 64'(wb_fen), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_rd", 64'(wb_rd), 64'(0));
        chk("t6_data", 64'(wb_data), 64'(0));
        chk("t6_src", 64'(wb_src), 64'(0));
        chk("t6_ready", 64'(req_ready), 64'(3'b111));
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        set_req(1, 1, 5'd8, 32'h88, 0);
        set_req(0, 1, 5'd9, 32'h99, 0);
        set_req(2, 1, 5'd10, 32'hAA, 0);
        cyc();
        req_valid = '0;
        cyc();
        chk("t6_first", 64'(wb_src), 64'(0));
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
